rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Parametrised, registered request arbiter for the Wishbone interconnect.
- Generalises the combinational priority encoder with:
  - a round-robin or fixed-priority mode
  - grant locking, either held for as long as the request stays up or held until the slave acknowledges
  - selectable LSB/MSB priority
- Sits in front of shared-slave muxes. Drives one-hot and encoded grant outputs to the crossbar.

Parameters:
- PORTS, 4: number of requesters. Legal range 2..32.
- ARB_TYPE_ROUND_ROBIN, 1: 1 = round robin; 0 = fixed priority.
- ARB_BLOCK, 1: 1 = a grant is held (locked) once issued; 0 = re-arbitrate every cycle.
- ARB_BLOCK_ACK, 0: only used when ARB_BLOCK=1. 1 = hold the grant until acknowledge_i of the granted port; 0 = hold while request_i of the granted port stays high.
- LSB_HIGH_PRIORITY, 1: 1 = bit 0 is highest priority; 0 = bit PORTS-1 is highest priority.

Ports:
- clk_i, input, 1: clock; all state changes on the rising edge.
- rst_ni, input, 1: asynchronous, active-low reset.
- request_i, input, PORTS: per-port request.
- acknowledge_i, input, PORTS: per-port transfer-complete strobe. Used only when ARB_BLOCK_ACK=1.
- grant_o, output, PORTS: one-hot grant, registered.
- grant_valid_o, output, 1: some port is granted, registered.
- grant_encoded_o, output, $clog2(PORTS): index of the granted port, registered.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - grant_o=0, grant_valid_o=0, grant_encoded_o=0.
  - RR mask = all ones, so there is no prior winner.
  - Reset must take effect immediately, including mid-grant.
- All outputs come from flops. Latency is one cycle from request_i to grant_o.
- Invariants:
  - grant_o is one-hot or zero.
  - grant_valid_o == |grant_o.
  - grant_encoded_o is the index of the set bit, or 0 when no bit is set.
- Next-state selection, evaluated every cycle with the first matching rule winning:
  1. ARB_BLOCK=1, ARB_BLOCK_ACK=0, and (grant_o & request_i) != 0: hold all outputs and the mask.
  2. ARB_BLOCK=1, ARB_BLOCK_ACK=1, grant_valid_o=1, and (grant_o & acknowledge_i) == 0: hold. The grant persists even if the granted request drops.
  3. request_i != 0: arbitrate (see below). Load grant_o, grant_encoded_o and grant_valid_o=1, and update the mask.
  4. Otherwise: grant_o=0, grant_valid_o=0, grant_encoded_o=0. The mask is unchanged.
- Arbitration:
  - Fixed priority: pick the highest-priority set bit of request_i.
  - Round robin: masked = request_i & mask.
    - If masked != 0, pick the highest-priority bit of masked.
    - Otherwise pick the highest-priority bit of request_i.
  - Mask update after a win at index k:
    - LSB_HIGH_PRIORITY=1: mask = bits strictly above k.
    - LSB_HIGH_PRIORITY=0: mask = bits strictly below k.
    - When k is the last port, the mask becomes 0, so the next arbitration falls back to unmasked. This is the wrap-around.
  - In fixed-priority mode the mask is unused and stays all ones.
- Acknowledge handling:
  - An acknowledge on a non-granted port is ignored.
  - In the ack cycle the grant is released and rule 3 applies in the same cycle, so there is no idle bubble if another request is pending.
- Simultaneous events:
  - In blocking-request mode, if the granted request drops while others are pending, the new grant appears on the next edge.
  - A newly rising higher-priority request never pre-empts a locked grant.
- The priority-pick logic is implemented as a parametrised loop or function with no width limit within 2..32.

Test Plan (PORTS=4 unless stated):
- RR, ARB_BLOCK=0, LSB_HIGH=1, request_i=4'b1111 steady → grant_o sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles; grant_encoded_o 0, 1, 2, 3, 0.
- Fixed priority, LSB_HIGH=0, request_i=4'b0101 → one cycle later grant_o=0100, grant_encoded_o=2. Changing request_i to 4'b0001 → grant_o=0001 the next cycle.
- RR, ARB_BLOCK=1, ARB_BLOCK_ACK=0, request_i=4'b0011 →
  - grant_o=0001, held for 5 cycles while request_i[0]=1; raising request_i[3] does not pre-empt.
  - Drop request_i[0] → the next cycle grant_o=0010.
- ARB_BLOCK_ACK=1 →
  - Grant port 2, then drop request_i[2]: grant_o stays 0100.
  - acknowledge_i=4'b0001 is ignored.
  - acknowledge_i=4'b0100 with request_i=4'b1000 → the next cycle grant_o=1000, with no idle cycle.
- Reset and idle:
  - Assert rst_ni low mid-grant → outputs go to 0 before the next clock edge.
  - After release, request_i=4'b1010 (RR, LSB_HIGH=1) → grant_o=0010.
  - request_i=0 → grant_valid_o=0 one cycle later.
- PORTS=2 and PORTS=32 builds: run the RR sweep with all requests high → every port is granted exactly once per PORTS cycles, and grant_encoded_o matches the one-hot grant.

Source files
------------

// File: rtl/rr_arbiter.sv
// Registered request arbiter for a Wishbone crossbar: round-robin or fixed priority,
// optional grant locking (held on request or until acknowledge), selectable priority end.
module rr_arbiter #(
  parameter int PORTS                = 4,
  parameter bit ARB_TYPE_ROUND_ROBIN = 1'b1,
  parameter bit ARB_BLOCK            = 1'b1,
  parameter bit ARB_BLOCK_ACK        = 1'b0,
  parameter bit LSB_HIGH_PRIORITY    = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [PORTS-1:0]         request_i,
  input  logic [PORTS-1:0]         acknowledge_i,
  output logic [PORTS-1:0]         grant_o,
  output logic                     grant_valid_o,
  output logic [$clog2(PORTS)-1:0] grant_encoded_o
);

  localparam int IDX_W = $clog2(PORTS);

  // Handshake: grant_valid_o qualifies grant_o/grant_encoded_o in the same cycle;
  // there is no back-pressure, a locked grant is released only by its own request/ack.

  logic [PORTS-1:0] r_grant;
  logic             r_valid;
  logic [IDX_W-1:0] r_enc;
  logic [PORTS-1:0] r_mask;

  logic [PORTS-1:0] w_masked;
  logic [PORTS-1:0] w_pick_src;
  logic [IDX_W-1:0] w_win;
  logic [PORTS-1:0] w_win_oh;
  logic             w_hold_req;
  logic             w_hold_ack;
  logic             w_hold;

  // Highest-priority set bit; the loop runs toward the high-priority end so it wins last.
  function automatic logic [IDX_W-1:0] pick_idx(input logic [PORTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    if (LSB_HIGH_PRIORITY) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (v[i]) idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  // Ports strictly lower in priority than the winner; empty after the last port wraps.
  function automatic logic [PORTS-1:0] mask_after(input logic [IDX_W-1:0] k);
    logic [PORTS-1:0] m;
    m = '0;
    for (int i = 0; i < PORTS; i++) begin
      m[i] = LSB_HIGH_PRIORITY ? (i > int'(k)) : (i < int'(k));
    end
    return m;
  endfunction

  always_comb begin
    w_masked   = request_i & r_mask;
    w_pick_src = (ARB_TYPE_ROUND_ROBIN && (|w_masked)) ? w_masked : request_i;
    w_win      = pick_idx(w_pick_src);
    w_win_oh   = '0;
    w_win_oh[w_win] = 1'b1;
    w_hold_req = ARB_BLOCK && !ARB_BLOCK_ACK && (|(r_grant & request_i));
    w_hold_ack = ARB_BLOCK && ARB_BLOCK_ACK && r_valid && !(|(r_grant & acknowledge_i));
    w_hold     = w_hold_req || w_hold_ack;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_grant <= '0;
      r_valid <= 1'b0;
      r_enc   <= '0;
      r_mask  <= '1;
    end else if (!w_hold) begin
      if (|request_i) begin
        r_grant <= w_win_oh;
        r_valid <= 1'b1;
        r_enc   <= w_win;
        if (ARB_TYPE_ROUND_ROBIN) r_mask <= mask_after(w_win);
      end else begin
        r_grant <= '0;
        r_valid <= 1'b0;
        r_enc   <= '0;
      end
    end
  end

  assign grant_o         = r_grant;
  assign grant_valid_o   = r_valid;
  assign grant_encoded_o = r_enc;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: several configurations share one stimulus stream and are
// compared each cycle against a rank-rotation reference model through an expected queue.
module tb_rr_arbiter;

  localparam int NI = 7;
  localparam int EN = 37;
  localparam int EW = NI * EN;

  // Instance configurations.
  function automatic int cfg_ports(input int k);
    case (k)
      4:       return 2;
      5:       return 32;
      default: return 4;
    endcase
  endfunction
  function automatic int cfg_rr(input int k);   return (k == 1) ? 0 : 1;            endfunction
  function automatic int cfg_blk(input int k);  return (k == 2 || k == 3) ? 1 : 0;  endfunction
  function automatic int cfg_ackm(input int k); return (k == 3) ? 1 : 0;            endfunction
  function automatic int cfg_lsb(input int k);  return (k == 1 || k == 6) ? 0 : 1;  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] req = '0;
  logic [31:0] ack = '0;

  logic [31:0] act_g [NI];
  logic        act_v [NI];
  logic [4:0]  act_e [NI];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int PK = cfg_ports(k);
    localparam int EK = $clog2(PK);
    logic [PK-1:0] g;
    logic          v;
    logic [EK-1:0] e;
    rr_arbiter #(
      .PORTS(PK),
      .ARB_TYPE_ROUND_ROBIN(cfg_rr(k) != 0),
      .ARB_BLOCK(cfg_blk(k) != 0),
      .ARB_BLOCK_ACK(cfg_ackm(k) != 0),
      .LSB_HIGH_PRIORITY(cfg_lsb(k) != 0)
    ) u_dut (
      .clk_i(clk),
      .rst_ni(rst_n),
      .request_i(req[PK-1:0]),
      .acknowledge_i(ack[PK-1:0]),
      .grant_o(g),
      .grant_valid_o(v),
      .grant_encoded_o(e)
    );
    assign act_g[k] = 32'(g);
    assign act_v[k] = v;
    assign act_e[k] = 5'(e);
  end

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  function automatic void chk(input string nm, input int k, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s inst=%0d got=%h exp=%h t=%0t", nm, k, act, exp, $time);
    end
  endfunction

  // Reference model: round robin is a scan of priority ranks starting just after the
  // last winner's rank (rank 0 = highest priority), wrapping around.
  logic [31:0] m_g    [NI];
  logic [4:0]  m_e    [NI];
  int          m_last [NI];

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_g[k] = '0;
      m_e[k] = '0;
      m_last[k] = -1;
    end
  endtask

  task automatic model_step(input int k, input logic [31:0] r, input logic [31:0] a);
    int p;
    logic [31:0] pm, rq, ak;
    p  = cfg_ports(k);
    pm = 32'((64'd1 << p) - 64'd1);
    rq = r & pm;
    ak = a & pm;
    if (cfg_blk(k) != 0 && cfg_ackm(k) == 0 && (m_g[k] & rq) != 0) return;
    if (cfg_blk(k) != 0 && cfg_ackm(k) != 0 && m_g[k] != 0 && (m_g[k] & ak) == 0) return;
    if (rq == 0) begin
      m_g[k] = '0;
      m_e[k] = '0;
      return;
    end
    for (int j = 0; j < p; j++) begin
      int rank, idx;
      rank = (cfg_rr(k) != 0) ? (m_last[k] + 1 + j) % p : j;
      idx  = (cfg_lsb(k) != 0) ? rank : p - 1 - rank;
      if (rq[idx]) begin
        m_g[k] = 32'd1 << idx;
        m_e[k] = 5'(idx);
        if (cfg_rr(k) != 0) m_last[k] = rank;
        return;
      end
    end
  endtask

  task automatic drive(input logic [31:0] r, input logic [31:0] a);
    logic [EW-1:0] ent;
    @(negedge clk);
    req = r;
    ack = a;
    ent = '0;
    for (int k = 0; k < NI; k++) begin
      model_step(k, r, a);
      ent[k*EN +: EN] = {m_g[k], m_e[k]};
    end
    exp_q.push_back(ent);
  endtask

  task automatic check_zero(input string nm);
    for (int k = 0; k < NI; k++) begin
      chk({nm, "_grant"}, k, act_g[k], 32'd0);
      chk({nm, "_valid"}, k, 32'(act_v[k]), 32'd0);
      chk({nm, "_enc"}, k, 32'(act_e[k]), 32'd0);
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    ack = '0;
    #1;
    check_zero("rst_async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expected entry per clock after outputs settle.
  logic [EW-1:0] mon_ent;
  logic [31:0]   mon_g;
  logic [4:0]    mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_ent = exp_q.pop_front();
      for (int k = 0; k < NI; k++) begin
        mon_g = mon_ent[k*EN+5 +: 32];
        mon_e = mon_ent[k*EN +: 5];
        chk("grant", k, act_g[k], mon_g);
        chk("valid", k, 32'(act_v[k]), 32'(mon_g != 0));
        chk("enc", k, 32'(act_e[k]), 32'(mon_e));
      end
    end
  end

  initial begin
    logic [31:0] r, a;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_zero("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin sweep with everything requesting (long enough for 32 ports twice).
    repeat (70) drive('1, '0);
    drive('0, '0);
    // Priority pick
    repeat (2) drive(32'b0101, '0);
    repeat (2) drive(32'b0001, '0);
    drive('0, '0);
    // Request-locked grant, higher request rises, then the holder drops.
    repeat (5) drive(32'b0011, '0);
    repeat (3) drive(32'b1011, '0);
    repeat (2) drive(32'b1010, '0);
    // Async reset in the middle of a grant, then restart and idle.
    reset_mid();
    drive(32'b1010, '0);
    drive('0, '0);
    drive('0, 32'b0010);
    // Ack-locked grant: request drops, foreign ack ignored, own ack hands over.
    drive(32'b0100, '0);
    repeat (2) drive('0, '0);
    drive('0, 32'b0001);
    drive(32'b1000, 32'b0100);
    repeat (2) drive(32'b1000, '0);
    drive('0, 32'b1000);

    r = '1;
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       r = '0;
          1:       r = '1;
          2:       r = $urandom & $urandom;
          default: r = $urandom;
        endcase
      end
      a = ($urandom_range(0, 2) == 0) ? (32'd1 << $urandom_range(0, 3)) : '0;
      drive(r, a);
      if (c == 250) reset_mid();
    end

    repeat (2) @(posedge clk);
    #3;
    chk("drain", 0, 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
